// File: rtl/clock_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : clock_period_meter
//  Description : Measures the period and high time of a slow asynchronous
//                signal in clk cycles and flags when consecutive periods match.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_period_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [1:0]       r_fill;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cap;
    logic [CNT_W-1:0] r_prev_period;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_hi_seen;
    logic             r_prev_ok;
    logic             r_valid;
    logic             r_locked;
    logic             r_overflow;

    logic             w_rise;
    logic             w_fall;
    logic             w_primed;
    logic             w_start;
    logic             w_capture;
    logic             w_ovf;

    assign w_rise   =  r_sync2 & ~r_prev;
    assign w_fall   = ~r_sync2 &  r_prev;
    // Reset clears the synchronizer, so a zero in it right after reset is not
    // a real observation of sig_in; wait until real samples have filled it.
    assign w_primed = r_fill[1];

    // Synchronize sig_in and keep one cycle of history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_fill  <= 2'b00;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_fill  <= {r_fill[0], 1'b1};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle measurement events
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_ovf       = 1'b0;
        case (r_state)
            WAIT_LOW: begin
                if (w_primed && !r_sync2) begin
                    w_state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    w_capture = 1'b1;
                end else if (r_cnt == C_CNT_MAX) begin
                    w_ovf       = 1'b1;
                    w_state_nxt = WAIT_LOW;
                end
            end
            default: w_state_nxt = WAIT_LOW;
        endcase
    end

    // Interval counter, high-time capture, result registers and lock tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_hi_cap      <= '0;
            r_hi_seen     <= 1'b0;
            r_prev_period <= '0;
            r_prev_ok     <= 1'b0;
            r_period      <= '0;
            r_high_time   <= '0;
            r_valid       <= 1'b0;
            r_locked      <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_start) begin
                r_cnt     <= C_ONE;
                r_hi_seen <= 1'b0;
            end else if (w_capture) begin
                r_period      <= r_cnt;
                r_high_time   <= r_hi_seen ? r_hi_cap : r_cnt;
                r_valid       <= 1'b1;
                r_locked      <= r_prev_ok && (r_cnt == r_prev_period);
                r_prev_period <= r_cnt;
                r_prev_ok     <= 1'b1;
                r_cnt         <= C_ONE;
                r_hi_seen     <= 1'b0;
            end else if (w_ovf) begin
                // Saturated with no rise: drop lock history, keep last results
                r_overflow <= 1'b1;
                r_locked   <= 1'b0;
                r_prev_ok  <= 1'b0;
            end else if (r_state == MEASURE) begin
                r_cnt <= r_cnt + C_ONE;
                if (w_fall && !r_hi_seen) begin
                    r_hi_cap  <= r_cnt;
                    r_hi_seen <= 1'b1;
                end
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign locked    = r_locked;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
